cpu_bus_responder: RTL and testbench

Memory-mapped target that answers CPU bus cycles on the shared 32-bit address/data bus. It holds a small word-addressed register bank that the CPU reads and writes through a req/ack handshake, with programmable wait states. It is the responder end of the bus the CPU core drives. It drives the shared data bus only while returning read data and is high-impedance at all other times.

---
 rtl/cpu_bus_if.sv | 43 ++++
 rtl/cpu_bus_responder.sv | 150 +++++++++++++++
 tb/tb_cpu_bus_responder.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_if.sv
// ---------------------------------------------------------------------------
// cpu_bus_if
//   Control/address side of the shared CPU bus between the CPU core (master)
//   and a memory-mapped responder (slave). The 32-bit data bus is bidirectional
//   and is kept as a plain inout port on each agent so that tristate
//   resolution stays at module level.
//
//   Signals
//     addr : byte address from the CPU
//     req  : CPU request, held high until ack is seen
//     we   : 1 = write, 0 = read, valid while req is high
//     ack  : one-cycle transfer-complete strobe from the responder
//     hit  : responder decodes addr as inside its window (combinational)
//
//   Handshake: the CPU raises req with addr/we (and write data on the data
//   bus) stable; the responder samples them on the first rising edge where
//   req && hit, and later pulses ack for exactly one cycle. The CPU must drop
//   req for at least one rising edge after ack before starting another
//   transfer; a req held through ack does not start a second transfer.
// ---------------------------------------------------------------------------
interface cpu_bus_if;
  logic [31:0] addr;
  logic        req;
  logic        we;
  logic        ack;
  logic        hit;

  modport master (
    output addr,
    output req,
    output we,
    input  ack,
    input  hit
  );

  modport slave (
    input  addr,
    input  req,
    input  we,
    output ack,
    output hit
  );
endinterface

// File: rtl/cpu_bus_responder.sv
// ---------------------------------------------------------------------------
// cpu_bus_responder
//   Memory-mapped register bank (2**ADDR_BITS 32-bit words) answering CPU bus
//   cycles through a req/ack handshake with WAIT_CYCLES wait states.
//   Full-word accesses only; addr[1:0] is ignored.
//
//   Ports
//     clk       : system clock, rising edge
//     rst_n     : asynchronous active-low reset (clears the bank too)
//     bus       : cpu_bus_if.slave (addr, req, we in; ack, hit out)
//     data      : shared 32-bit data bus; sampled at request time on writes,
//                 driven with read data only during the ack cycle of a read
//     dbg_state : current FSM state (IDLE=0, WAIT=1, ACK=2, HOLD=3)
//
//   Timing: with req sampled at edge N, ack is high in the cycle following
//   edge N+WAIT_CYCLES. A write lands in the bank on the edge entering ACK.
//   Dropping req during WAIT abandons the transfer (no write, no ack).
// ---------------------------------------------------------------------------
module cpu_bus_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          ADDR_BITS   = 4,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  cpu_bus_if.slave      bus,
  inout  wire  [31:0]   data,
  output logic [1:0]    dbg_state
);

  localparam int         WORDS     = 1 << ADDR_BITS;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]           state;
  logic [1:0]           state_nx;
  logic [3:0]           cnt;
  logic [ADDR_BITS-1:0] idx_q;
  logic                 we_q;
  logic [31:0]          wdata_q;
  logic [31:0]          bank [WORDS];

  logic [ADDR_BITS-1:0] idx_in;
  logic                 start;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_idx;
  logic [31:0]          wr_data;
  logic                 rd_drive;

  // Byte-lane bits carry no meaning here: every access is a full word.
  logic                 unused_addr_bits;
  assign unused_addr_bits = ^bus.addr[1:0];

  // ---------------------------------------------------------------- decode
  assign bus.hit = (bus.addr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
  assign idx_in  = bus.addr[ADDR_BITS+1:2];
  assign start   = (state == S_IDLE) && bus.req && bus.hit;

  // ------------------------------------------------------- next state/write
  // The bank write happens on the edge that enters ACK. With no wait states
  // that edge is the request edge itself, so the live bus values are used;
  // otherwise the values latched at request time are used.
  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    wr_idx   = idx_q;
    wr_data  = wdata_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (WAIT_CYCLES == 0) begin
            state_nx = S_ACK;
            wr_en    = bus.we;
            wr_idx   = idx_in;
            wr_data  = data;
          end else begin
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Abort has priority over completion: req low on the final wait
        // edge still cancels the transfer.
        if (!bus.req) begin
          state_nx = S_IDLE;
        end else if (cnt == 4'd1) begin
          state_nx = S_ACK;
          wr_en    = we_q;
        end
      end
      S_ACK: begin
        state_nx = bus.req ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        // A req still held from the completed transfer must not be taken
        // as a new one; wait for it to go low first.
        if (!bus.req) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // ------------------------------------------------------ control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        // addr/we/data are captured once; later changes are ignored.
        idx_q   <= idx_in;
        we_q    <= bus.we;
        wdata_q <= data;
        cnt     <= WAIT_INIT;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // ----------------------------------------------------------- register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) begin
        bank[i] <= '0;
      end
    end else if (wr_en) begin
      bank[wr_idx] <= wr_data;
    end
  end

  // ------------------------------------------------------------------ outputs
  // The bus is driven only in the ACK cycle of a read. ACK is always followed
  // by IDLE or HOLD, so two driven cycles are never adjacent.
  assign rd_drive  = (state == S_ACK) && !we_q;
  assign data      = rd_drive ? bank[idx_q] : 32'bz;
  assign bus.ack   = (state == S_ACK);
  assign dbg_state = state;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_cpu_bus_responder
//   Two responders share one clock: dut_a with 2 wait states and dut_b with
//   none. Drivers issue bus transfers and push the expected ack cycle and
//   read value into a per-DUT queue; a monitor on the falling edge pops and
//   compares on every ack, and otherwise checks that the data bus is released
//   (a pull-up makes a released bus read as all ones).
// ---------------------------------------------------------------------------
module tb_cpu_bus_responder;

  localparam int          WA     = 2;
  localparam int          WB     = 0;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] PULLED = 32'hFFFF_FFFF;

  // ------------------------------------------------------- clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a;
  logic rst_n_b;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ------------------------------------------------------------- DUT wiring
  cpu_bus_if bus_a ();
  cpu_bus_if bus_b ();

  logic [1:0]  req_v;
  logic [1:0]  we_v;
  logic [1:0]  drv_v;
  logic [31:0] addr_v [2];
  logic [31:0] wd_v   [2];

  wire  [31:0] data_a;
  wire  [31:0] data_b;
  logic [1:0]  unused_dbg_a;
  logic [1:0]  unused_dbg_b;

  assign bus_a.addr = addr_v[0];
  assign bus_a.req  = req_v[0];
  assign bus_a.we   = we_v[0];
  assign bus_b.addr = addr_v[1];
  assign bus_b.req  = req_v[1];
  assign bus_b.we   = we_v[1];

  assign data_a = drv_v[0] ? wd_v[0] : 32'bz;
  assign data_b = drv_v[1] ? wd_v[1] : 32'bz;

  for (genvar i = 0; i < 32; i++) begin : g_pull
    pullup (data_a[i]);
    pullup (data_b[i]);
  end

  wire [1:0] ack_v = {bus_b.ack, bus_a.ack};
  wire [1:0] hit_v = {bus_b.hit, bus_a.hit};

  cpu_bus_responder #(.BASE_ADDR(BASE), .ADDR_BITS(4), .WAIT_CYCLES(WA)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n_a),
    .bus       (bus_a.slave),
    .data      (data_a),
    .dbg_state (unused_dbg_a)
  );

  cpu_bus_responder #(.BASE_ADDR(BASE), .ADDR_BITS(4), .WAIT_CYCLES(WB)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n_b),
    .bus       (bus_b.slave),
    .data      (data_b),
    .dbg_state (unused_dbg_b)
  );

  // ------------------------------------------------------ reference model
  logic [31:0] mem_m [2][16];

  function automatic logic model_hit(input logic [31:0] a);
    return (a / 64) == (BASE / 64);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a % 64) / 4);
  endfunction

  function automatic int wait_of(input int d);
    return (d == 0) ? WA : WB;
  endfunction

  // -------------------------------------------------------------- scoreboard
  // Entry: {expected ack cycle[31:0], we, expected read data[31:0]}
  logic [64:0] exp_q0 [$];
  logic [64:0] exp_q1 [$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @cyc %0d: got %h, wanted %h", name, d, cyc, act, exp);
    end
  endtask

  task automatic mon_one(input int d, input logic ak, input logic [31:0] dv,
                         input logic drv);
    logic [64:0] e;
    int          qs;
    qs = (d == 0) ? exp_q0.size() : exp_q1.size();
    if (ak) begin
      if (qs == 0) begin
        check("unexpected_ack", d, 32'd1, 32'd0);
      end else begin
        if (d == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        check("ack_cycle", d, cyc, e[64:33]);
        if (!e[32]) check("read_data", d, dv, e[31:0]);
      end
    end else if (!drv) begin
      check("bus_released", d, dv, PULLED);
    end
  endtask

  always @(negedge clk) begin
    mon_one(0, ack_v[0], data_a, drv_v[0]);
    mon_one(1, ack_v[1], data_b, drv_v[1]);
  end

  // ---------------------------------------------------------------- drivers
  // Inputs change 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic xfer(input int d, input logic [31:0] a, input logic w,
                      input logic [31:0] wd, input int hold);
    logic        exp_hit;
    logic [31:0] rd;
    bit          seen;
    int          acks;
    step();
    addr_v[d] = a;
    we_v[d]   = w;
    wd_v[d]   = wd;
    drv_v[d]  = w;
    req_v[d]  = 1'b1;
    #1;
    exp_hit = model_hit(a);
    check("hit", d, {31'd0, hit_v[d]}, {31'd0, exp_hit});
    if (exp_hit) begin
      rd = mem_m[d][model_idx(a)];
      if (d == 0) exp_q0.push_back({32'(cyc + 1 + wait_of(d)), w, rd});
      else        exp_q1.push_back({32'(cyc + 1 + wait_of(d)), w, rd});
      if (w) mem_m[d][model_idx(a)] = wd;
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
        step();
        // Request already sampled: later changes must be ignored.
        addr_v[d] = $urandom;
        wd_v[d]   = $urandom;
        if (ack_v[d]) seen = 1'b1;
      end
      if (!seen) check("ack_timeout", d, 32'd0, 32'd1);
      for (int k = 0; k < hold; k++) step();
    end else begin
      acks = 0;
      for (int k = 0; k < 20; k++) begin
        step();
        if (ack_v[d]) acks++;
      end
      check("miss_no_ack", d, 32'(acks), 32'd0);
    end
    req_v[d] = 1'b0;
    drv_v[d] = 1'b0;
  endtask

  // Write whose req is withdrawn in the first wait cycle.
  task automatic abort_write(input int d, input logic [31:0] a, input logic [31:0] wd);
    step();
    addr_v[d] = a;
    we_v[d]   = 1'b1;
    wd_v[d]   = wd;
    drv_v[d]  = 1'b1;
    req_v[d]  = 1'b1;
    #1;
    check("hit_abort", d, {31'd0, hit_v[d]}, 32'd1);
    step();
    req_v[d] = 1'b0;
    drv_v[d] = 1'b0;
    for (int k = 0; k < 6; k++) step();
  endtask

  function automatic logic [31:0] rand_word();
    return $urandom & 32'hFFFF_FFFE;
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst_n_a  = 1'b0;
    rst_n_b  = 1'b0;
    req_v    = '0;
    we_v     = '0;
    drv_v    = '0;
    addr_v[0] = '0; addr_v[1] = '0;
    wd_v[0]   = '0; wd_v[1]   = '0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) mem_m[d][i] = '0;

    repeat (3) step();
    check("rst_ack_a", 0, {31'd0, ack_v[0]}, 32'd0);
    check("rst_ack_b", 1, {31'd0, ack_v[1]}, 32'd0);
    check("rst_data_a", 0, data_a, PULLED);
    check("rst_data_b", 1, data_b, PULLED);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // Basic read after reset, then write/read-back with byte offset alias.
    xfer(0, 32'h0000_1008, 1'b0, '0, 0);
    xfer(0, 32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 0);
    xfer(0, 32'h0000_1004, 1'b0, '0, 0);
    xfer(0, 32'h0000_1005, 1'b0, '0, 0);
    xfer(0, 32'h0000_1000, 1'b0, '0, 0);

    // Outside the window: never answered.
    xfer(0, 32'h0000_2000, 1'b0, '0, 0);
    xfer(0, 32'h0000_0FFC, 1'b1, 32'h1111_2222, 0);
    xfer(0, 32'h0000_1040, 1'b0, '0, 0);

    // Withdrawn write leaves the word untouched; the next request still works.
    abort_write(0, 32'h0000_103C, 32'hCAFE_F00D);
    xfer(0, 32'h0000_103C, 1'b0, '0, 0);
    xfer(0, 32'h0000_1008, 1'b0, '0, 0);

    // req held 10 cycles past ack gives one ack only; then a fresh request.
    xfer(0, 32'h0000_1004, 1'b0, '0, 10);
    xfer(0, 32'h0000_1004, 1'b0, '0, 0);

    // Randomised traffic on the waited responder.
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = 32'h0000_2000 + $urandom_range(0, 4095);
      else                          a = BASE + $urandom_range(0, 63);
      xfer(0, a, 1'($urandom_range(0, 1)), rand_word(), $urandom_range(0, 2));
    end

    // Zero-wait responder: ack the cycle after the request.
    xfer(1, 32'h0000_1010, 1'b1, 32'h1234_5678, 0);
    xfer(1, 32'h0000_1010, 1'b0, '0, 0);
    for (int n = 0; n < 30; n++) begin
      xfer(1, BASE + $urandom_range(0, 63), 1'($urandom_range(0, 1)), rand_word(),
           $urandom_range(0, 3));
    end

    // Reset during a read ack: ack and bus drop at once, bank is cleared.
    step();
    addr_v[1] = 32'h0000_1010;
    we_v[1]   = 1'b0;
    req_v[1]  = 1'b1;
    step();
    check("pre_rst_ack", 1, {31'd0, ack_v[1]}, 32'd1);
    check("pre_rst_data", 1, data_b, mem_m[1][4]);
    rst_n_b = 1'b0;
    #1;
    check("mid_rst_ack", 1, {31'd0, ack_v[1]}, 32'd0);
    check("mid_rst_data", 1, data_b, PULLED);
    req_v[1] = 1'b0;
    for (int i = 0; i < 16; i++) mem_m[1][i] = '0;
    step();
    rst_n_b = 1'b1;
    xfer(1, 32'h0000_1010, 1'b0, '0, 0);
    xfer(1, 32'h0000_1004, 1'b0, '0, 0);

    repeat (5) step();
    check("drain_q0", 0, 32'(exp_q0.size()), 32'd0);
    check("drain_q1", 1, 32'(exp_q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
